// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller:
// StallBus encodings, mult/div sequencer states and the counter load helper.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Cycle 0 is the md_start cycle and the last count value is spent in MD_RUN,
  // so the counter is loaded with N-2.
  function automatic logic [5:0] md_load(input logic        is_div,
                                         input int unsigned div_cycles,
                                         input int unsigned mul_cycles);
    int unsigned n;
    n = is_div ? div_cycles : mul_cycles;
    return 6'(n - 2);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side handshake bundle for pipe_ctrl: stall requests in, StallBus,
// flush and mult/div status out.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic       stallreq_from_id;
  logic       stallreq_from_ex;
  logic       stallreq_from_mem;
  logic       md_start;
  logic       md_is_div;
  logic       flush_req;
  stall_bus_t stall;
  logic       flush;
  logic       md_busy;
  logic       md_done;

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  md_start, md_is_div, flush_req,
    output stall, flush, md_busy, md_done
  );

  modport master (
    output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output md_start, md_is_div, flush_req,
    input  stall, flush, md_busy, md_done
  );

endinterface

// File: rtl/pipe_ctrl_md_seq.sv
// Mult/div sequencer: holds EX for the unit's fixed latency and pulses md_done.
// state   | meaning
// IDLE    | no op in flight; md_start (without flush) launches one
// MD_RUN  | unit computing; cnt counts down to the last hold cycle
// MD_DONE | result ready, md_done high, EX released; md_start accepted again
module pipe_ctrl_md_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start_i,
  input  logic md_is_div_i,
  input  logic flush_req_i,
  output logic md_hold_o,
  output logic md_busy_o,
  output logic md_done_o
);

  md_state_e  state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_hold_o = 1'b0;
    md_busy_o = 1'b0;
    md_done_o = 1'b0;
    case (state_q)
      IDLE, MD_DONE: begin
        md_done_o = (state_q == MD_DONE);
        state_d   = IDLE;
        if (md_start_i) begin
          md_hold_o = 1'b1;
          if (!flush_req_i) begin
            state_d = MD_RUN;
            cnt_d   = md_load(md_is_div_i, DIV_CYCLES, MUL_CYCLES);
          end
        end
      end
      MD_RUN: begin
        md_hold_o = 1'b1;
        md_busy_o = 1'b1;
        if (cnt_q == 6'd0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // An aborted op never reaches MD_DONE, so no md_done is issued for it.
    if (flush_req_i) begin
      state_d = IDLE;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority-merges stall requests into StallBus
// and sequences the mult/div unit. Optional perf counters under CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CTRL_PERF_EN
  output logic [31:0] perf_stall_cycles_o,
  output logic [31:0] perf_lu_stalls_o,
`endif
  pipe_ctrl_if.slave  bus
);

  logic       md_hold;
  stall_bus_t stall_sel;

  pipe_ctrl_md_seq #(
    .DIV_CYCLES (DIV_CYCLES),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_md_seq (
    .clk         (clk),
    .rst         (rst),
    .md_start_i  (bus.md_start),
    .md_is_div_i (bus.md_is_div),
    .flush_req_i (bus.flush_req),
    .md_hold_o   (md_hold),
    .md_busy_o   (bus.md_busy),
    .md_done_o   (bus.md_done)
  );

  always_comb begin
    stall_sel = STALL_NONE;
    if (bus.flush_req) begin
      stall_sel = STALL_NONE;
    end else if (bus.stallreq_from_mem) begin
      stall_sel = STALL_MEM;
    end else if (md_hold || bus.stallreq_from_ex) begin
      stall_sel = STALL_EX;
    end else if (bus.stallreq_from_id) begin
      stall_sel = STALL_ID;
    end
  end

  assign bus.stall = stall_sel;
  assign bus.flush = bus.flush_req;

`ifdef CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_lu_q;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= 32'd0;
      perf_lu_q    <= 32'd0;
    end else if (!bus.flush_req) begin
      if (stall_sel[0] == STOP) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (stall_sel == STALL_ID) begin
        perf_lu_q <= perf_lu_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_lu_stalls_o    = perf_lu_q;
`endif

endmodule
